// File: rtl/hba_reg_file.sv
// hba_reg_file: HBA bus slave with NUM_REGS RW/RO registers and per-register write strobes.
// Define HBA_REG_FILE_IRQ_EN to enable change-detect interrupts on read-only inputs.
module hba_reg_file #(
   parameter int DBUS_WIDTH = 8,
   parameter int PERIPH_ADDR_WIDTH = 4,
   parameter int REG_ADDR_WIDTH = 8,
   parameter int ADDR_WIDTH = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
   parameter logic [PERIPH_ADDR_WIDTH-1:0] PERIPH_ADDR = '0,
   parameter int NUM_REGS = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK = 8'hC0
) (
   input  logic                           hba_clk,
   input  logic                           hba_reset_n,
   input  logic                           hba_rnw,
   input  logic                           hba_select,
   input  logic [ADDR_WIDTH-1:0]          hba_abus,
   input  logic [DBUS_WIDTH-1:0]          hba_dbus,
   output logic [DBUS_WIDTH-1:0]          regfile_dbus,
   output logic                           regfile_xferack,
   output logic                           regfile_interrupt,
   output logic [NUM_REGS*DBUS_WIDTH-1:0] regs_out,
   input  logic [NUM_REGS*DBUS_WIDTH-1:0] regs_in,
   output logic [NUM_REGS-1:0]            reg_wstb
);
   localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, WAIT = 2'd3;
   logic [1:0] state, next_state;
   logic addr_hit;
   logic [REG_ADDR_WIDTH-1:0] idx;
   logic [DBUS_WIDTH-1:0] rd_data;
   logic [NUM_REGS-1:0] wr_hit;
   assign idx = hba_abus[REG_ADDR_WIDTH-1:0];
   assign next_state = state == IDLE ? (addr_hit ? (hba_rnw ? READ : WRITE) : IDLE) :
                       (state == READ || state == WRITE) ? WAIT : IDLE;
   // Unmapped indices match no slot, so they read 0 and write nothing.
   always_comb begin
      rd_data = '0;
      wr_hit = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == REG_ADDR_WIDTH'(i))
            rd_data = RO_MASK[i] ? regs_in[i*DBUS_WIDTH +: DBUS_WIDTH] : regs_out[i*DBUS_WIDTH +: DBUS_WIDTH];
         wr_hit[i] = state == WRITE && idx == REG_ADDR_WIDTH'(i) && !RO_MASK[i];
      end
   end
   always_ff @(posedge hba_clk or negedge hba_reset_n) begin
      if (!hba_reset_n) begin
         state <= IDLE;
         addr_hit <= 1'b0;
         regfile_xferack <= 1'b0;
         regfile_dbus <= '0;
         regs_out <= '0;
         reg_wstb <= '0;
      end else begin
         state <= next_state;
         addr_hit <= hba_select && !regfile_xferack &&
                     hba_abus[ADDR_WIDTH-1 -: PERIPH_ADDR_WIDTH] == PERIPH_ADDR;
         regfile_xferack <= state == READ || state == WRITE;
         regfile_dbus <= state == READ ? rd_data : '0;
         reg_wstb <= wr_hit;
         for (int i = 0; i < NUM_REGS; i++)
            if (wr_hit[i]) regs_out[i*DBUS_WIDTH +: DBUS_WIDTH] <= hba_dbus;
      end
   end
`ifdef HBA_REG_FILE_IRQ_EN
   logic [NUM_REGS*DBUS_WIDTH-1:0] hw_q;
   logic [NUM_REGS-1:0] pending, chg, rd_clr;
   logic irq_q;
   always_comb begin
      chg = '0;
      rd_clr = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         chg[i] = RO_MASK[i] && regs_in[i*DBUS_WIDTH +: DBUS_WIDTH] != hw_q[i*DBUS_WIDTH +: DBUS_WIDTH];
         rd_clr[i] = state == READ && idx == REG_ADDR_WIDTH'(i);
      end
   end
   // A change arriving in the clearing read cycle keeps the request alive.
   always_ff @(posedge hba_clk or negedge hba_reset_n) begin
      if (!hba_reset_n) begin
         hw_q <= '0;
         pending <= '0;
         irq_q <= 1'b0;
      end else begin
         hw_q <= regs_in;
         pending <= chg | (pending & ~rd_clr);
         irq_q <= |pending;
      end
   end
   assign regfile_interrupt = irq_q;
`else
   assign regfile_interrupt = 1'b0;
`endif
endmodule
